// File: rtl/stq_pkg.sv
// Shared types for the store queue: entry layout, pointer/slot types and the
// age-rank helper used by both the occupancy check and the forwarding selector.
package stq_pkg;

    localparam int STQ_DEPTH_EXP  = 3;
    localparam int STQ_DEPTH      = 1 << STQ_DEPTH_EXP;
    localparam int STQ_ADDR_BITS  = 30;
    localparam int STQ_DATA_BYTES = 4;
    localparam int STQ_DATA_BITS  = 8 * STQ_DATA_BYTES;

    // Pointers carry one extra MSB as the wrap bit.
    typedef logic [STQ_DEPTH_EXP:0]   stq_ptr_t;
    typedef logic [STQ_DEPTH_EXP-1:0] stq_slot_t;

    typedef struct packed {
        logic [STQ_ADDR_BITS-1:0]  addr;
        logic [STQ_DATA_BITS-1:0]  data;
        logic [STQ_DATA_BYTES-1:0] mask;
    } stq_entry_t;

    // Distance of a slot from the oldest entry; larger means younger.
    function automatic stq_slot_t stq_age_rank(input stq_slot_t slot, input stq_slot_t head);
        return slot - head;
    endfunction

endpackage

// File: rtl/stq_fwd_sel.sv
// Combinational per-byte forwarding selector: for every requested byte, pick
// the youngest live entry whose address matches and whose byte enable is set.
module stq_fwd_sel
    import stq_pkg::*;
(
    input  stq_entry_t                entries [STQ_DEPTH],
    input  logic [STQ_DEPTH-1:0]      valid,
    input  stq_slot_t                 head,
    input  logic [STQ_ADDR_BITS-1:0]  ld_addr,
    input  logic [STQ_DATA_BYTES-1:0] ld_mask,
    output logic [STQ_DATA_BYTES-1:0] sel_mask,
    output logic [STQ_DATA_BITS-1:0]  sel_data
);

    logic [STQ_DEPTH-1:0] addr_hit;

    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            addr_hit[i] = valid[i] && (entries[i].addr == ld_addr);
        end
    end

    always_comb begin
        stq_slot_t rank;
        stq_slot_t best;
        sel_mask = '0;
        sel_data = '0;
        rank     = '0;
        best     = '0;
        for (int b = 0; b < STQ_DATA_BYTES; b++) begin
            best = '0;
            for (int i = 0; i < STQ_DEPTH; i++) begin
                if (addr_hit[i] && entries[i].mask[b] && ld_mask[b]) begin
                    rank = stq_age_rank(stq_slot_t'(i), head);
                    // Ranks are unique, so the strictly larger one is the younger store.
                    if (!sel_mask[b] || rank > best) begin
                        sel_mask[b]          = 1'b1;
                        best                 = rank;
                        sel_data[8*b +: 8]   = entries[i].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// Store queue: speculative allocation, in-order commit, kill of uncommitted
// stores, oldest-first drain and registered byte-granular load forwarding.
module store_queue
    import stq_pkg::*;
#(
    parameter int DEPTH_EXP  = STQ_DEPTH_EXP,
    parameter int ADDR_BITS  = STQ_ADDR_BITS,
    parameter int DATA_BYTES = STQ_DATA_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [ADDR_BITS-1:0]    enq_addr,
    input  logic [8*DATA_BYTES-1:0] enq_data,
    input  logic [DATA_BYTES-1:0]   enq_mask,
    input  logic                    commit,
    input  logic                    kill,
    output logic                    drain_valid,
    input  logic                    drain_ready,
    output logic [ADDR_BITS-1:0]    drain_addr,
    output logic [8*DATA_BYTES-1:0] drain_data,
    output logic [DATA_BYTES-1:0]   drain_mask,
    input  logic                    ld_valid,
    input  logic [ADDR_BITS-1:0]    ld_addr,
    input  logic [DATA_BYTES-1:0]   ld_mask,
    output logic                    fwd_valid,
    output logic [DATA_BYTES-1:0]   fwd_mask,
    output logic [8*DATA_BYTES-1:0] fwd_data,
    output logic                    fwd_full,
    output logic [DEPTH_EXP:0]      count,
    output logic                    empty,
    output logic                    full
);

    localparam int       DEPTH   = 1 << DEPTH_EXP;
    localparam stq_ptr_t PTR_ONE = stq_ptr_t'(1);

    stq_entry_t mem [DEPTH];

    stq_ptr_t  head, cmt, tail;
    stq_ptr_t  head_nxt, cmt_nxt, tail_nxt, tail_enq;
    stq_slot_t head_slot, tail_slot;
    stq_ptr_t  occ;

    logic enq_fire, drain_fire, commit_ok;

    logic [DEPTH-1:0]        live;
    logic [DATA_BYTES-1:0]   sel_mask;
    logic [8*DATA_BYTES-1:0] sel_data;

    logic                    fwd_valid_p1;
    logic [DATA_BYTES-1:0]   fwd_mask_p1;
    logic [8*DATA_BYTES-1:0] fwd_data_p1;
    logic                    fwd_full_p1;

    assign head_slot = head[DEPTH_EXP-1:0];
    assign tail_slot = tail[DEPTH_EXP-1:0];
    assign occ       = tail - head;

    assign full        = (tail[DEPTH_EXP] != head[DEPTH_EXP]) && (tail_slot == head_slot);
    assign empty       = (tail == head);
    assign count       = occ;
    assign enq_ready   = !full && !kill;
    assign drain_valid = (head != cmt);

    assign enq_fire   = enq_valid && enq_ready;
    assign drain_fire = drain_valid && drain_ready;

    // Same-cycle order: drain, enqueue, commit, kill. Kill rolls tail back to
    // the post-commit cmt so a commit issued alongside kill still survives.
    always_comb begin
        head_nxt  = head + (drain_fire ? PTR_ONE : '0);
        tail_enq  = tail + (enq_fire ? PTR_ONE : '0);
        commit_ok = commit && (cmt != tail_enq);
        cmt_nxt   = cmt + (commit_ok ? PTR_ONE : '0);
        tail_nxt  = kill ? cmt_nxt : tail_enq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            cmt  <= cmt_nxt;
            tail <= tail_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail_slot] <= '{addr: enq_addr, data: enq_data, mask: enq_mask};
        end
    end

    assign drain_addr = mem[head_slot].addr;
    assign drain_data = mem[head_slot].data;
    assign drain_mask = mem[head_slot].mask;

    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, stq_age_rank(stq_slot_t'(i), head_slot)} < occ);
        end
    end

    stq_fwd_sel u_fwd_sel (
        .entries  (mem),
        .valid    (live),
        .head     (head_slot),
        .ld_addr  (ld_addr),
        .ld_mask  (ld_mask),
        .sel_mask (sel_mask),
        .sel_data (sel_data)
    );

    // ---- stage p1: registered lookup result ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid_p1 <= 1'b0;
            fwd_mask_p1  <= '0;
            fwd_data_p1  <= '0;
            fwd_full_p1  <= 1'b0;
        end else begin
            fwd_valid_p1 <= ld_valid;
            if (ld_valid) begin
                fwd_mask_p1 <= sel_mask;
                fwd_data_p1 <= sel_data;
                fwd_full_p1 <= (sel_mask == ld_mask);
            end
        end
    end

    assign fwd_valid = fwd_valid_p1;
    assign fwd_mask  = fwd_mask_p1;
    assign fwd_data  = fwd_data_p1;
    assign fwd_full  = fwd_full_p1;

endmodule

// File: tb/tb_store_queue.sv
// Scoreboard bench for store_queue: a queue-based reference model predicts
// status, drain contents and forwarding results cycle by cycle.
module tb_store_queue;
    import stq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, enq_ready;
    logic [29:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_mask;
    logic        commit, kill;
    logic        drain_valid, drain_ready;
    logic [29:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_mask;
    logic        ld_valid;
    logic [29:0] ld_addr;
    logic [3:0]  ld_mask;
    logic        fwd_valid;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic        fwd_full;
    logic [3:0]  count;
    logic        empty, full;

    always #5 clk = ~clk;

    store_queue dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_mask(enq_mask),
        .commit(commit), .kill(kill),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_data(drain_data), .drain_mask(drain_mask),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask),
        .fwd_valid(fwd_valid), .fwd_mask(fwd_mask), .fwd_data(fwd_data), .fwd_full(fwd_full),
        .count(count), .empty(empty), .full(full)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  m;
        logic [31:0] d;
        logic        f;
    } fwd_exp_t;

    stq_entry_t mq[$];
    int         mcmt;
    fwd_exp_t   exp_fwd[$];
    bit         fwd_pend;

    logic        s_ev, s_commit, s_kill, s_dr, s_ldv;
    logic [29:0] s_addr, s_lda;
    logic [31:0] s_data;
    logic [3:0]  s_mask, s_ldm;

    task automatic clear_stage();
        s_ev = 0; s_commit = 0; s_kill = 0; s_dr = 0; s_ldv = 0;
        s_addr = '0; s_lda = '0; s_data = '0; s_mask = '0; s_ldm = '0;
    endtask

    task automatic drive_idle();
        enq_valid = 0; enq_addr = '0; enq_data = '0; enq_mask = '0;
        commit = 0; kill = 0; drain_ready = 0;
        ld_valid = 0; ld_addr = '0; ld_mask = '0;
    endtask

    task automatic tick();
        fwd_exp_t   e;
        stq_entry_t ne;
        bit         dv, ef, df;
        @(negedge clk);
        enq_valid = s_ev; enq_addr = s_addr; enq_data = s_data; enq_mask = s_mask;
        commit = s_commit; kill = s_kill; drain_ready = s_dr;
        ld_valid = s_ldv; ld_addr = s_lda; ld_mask = s_ldm;
        #1;
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == 8);
        dv = (mcmt > 0);
        chk("drain_valid", drain_valid, dv);
        chk("enq_ready", enq_ready, (mq.size() < 8) && !s_kill);
        if (dv) begin
            chk("drain_addr", drain_addr, mq[0].addr);
            chk("drain_data", drain_data, mq[0].data);
            chk("drain_mask", drain_mask, mq[0].mask);
        end
        chk("fwd_valid", fwd_valid, fwd_pend);
        if (fwd_pend && exp_fwd.size() > 0) begin
            e = exp_fwd.pop_front();
            chk("fwd_mask", fwd_mask, e.m);
            chk("fwd_data", fwd_data, e.d);
            chk("fwd_full", fwd_full, e.f);
        end
        if (s_ldv) begin
            e.m = '0;
            e.d = '0;
            for (int b = 0; b < 4; b++) begin
                if (s_ldm[b]) begin
                    for (int i = mq.size() - 1; i >= 0; i--) begin
                        if (mq[i].addr == s_lda && mq[i].mask[b]) begin
                            e.m[b]         = 1'b1;
                            e.d[8*b +: 8]  = mq[i].data[8*b +: 8];
                            break;
                        end
                    end
                end
            end
            e.f = ((e.m & s_ldm) == s_ldm);
            exp_fwd.push_back(e);
        end
        fwd_pend = s_ldv;
        ef = s_ev && (mq.size() < 8) && !s_kill;
        df = dv && s_dr;
        @(posedge clk);
        if (df) begin
            void'(mq.pop_front());
            mcmt--;
        end
        if (ef) begin
            ne.addr = s_addr; ne.data = s_data; ne.mask = s_mask;
            mq.push_back(ne);
        end
        if (s_commit && mcmt < mq.size()) mcmt++;
        if (s_kill) while (mq.size() > mcmt) void'(mq.pop_back());
        clear_stage();
    endtask

    task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        s_ev = 1; s_addr = a; s_data = d; s_mask = m;
        tick();
    endtask

    task automatic lookup(input logic [29:0] a, input logic [3:0] m);
        s_ldv = 1; s_lda = a; s_ldm = m;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fwd_valid"}, fwd_valid, 0);
        chk({tag, "_fwd_mask"}, fwd_mask, 0);
        chk({tag, "_fwd_data"}, fwd_data, 0);
        chk({tag, "_fwd_full"}, fwd_full, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_drain_valid"}, drain_valid, 0);
        chk({tag, "_enq_ready"}, enq_ready, 1);
    endtask

    task automatic do_reset();
        rst = 0;
        drive_idle();
        clear_stage();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        mq.delete();
        mcmt = 0;
        exp_fwd.delete();
        fwd_pend = 0;
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        rst = 0;
        mcmt = 0;
        fwd_pend = 0;
        drive_idle();
        clear_stage();

        // Fill to capacity, then attempt a ninth allocation.
        do_reset();
        for (int i = 0; i < 8; i++) enq(30'h10 + 30'(i), 32'hA000_0000 + 32'(i), 4'hF);
        #1;
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        enq(30'h18, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("ninth_count", count, 8);
        tick();

        // Byte merge from two stores to the same word.
        do_reset();
        enq(30'h40, 32'h1122_3344, 4'hF);
        enq(30'h40, 32'h0000_AABB, 4'h3);
        lookup(30'h40, 4'hF);
        #1;
        chk("merge_data", fwd_data, 32'h1122_AABB);
        chk("merge_full", fwd_full, 1);
        tick();

        // Partial coverage, address miss, empty load mask.
        enq(30'h80, 32'h0000_00CC, 4'h1);
        lookup(30'h80, 4'h3);
        #1;
        chk("partial_mask", fwd_mask, 4'h1);
        chk("partial_full", fwd_full, 0);
        lookup(30'h84, 4'hF);
        #1;
        chk("miss_mask", fwd_mask, 4'h0);
        lookup(30'h80, 4'h0);
        #1;
        chk("zero_ld_full", fwd_full, 1);
        tick();

        // Commit/kill interplay and held drain.
        do_reset();
        for (int i = 0; i < 4; i++) enq(30'h60 + 30'(i), 32'h6000_0000 + 32'(i), 4'hF);
        s_commit = 1; tick();
        s_commit = 1; tick();
        s_commit = 1; s_kill = 1; tick();
        #1;
        chk("kill_count", count, 3);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            s_dr = 1; tick();
        end
        #1;
        chk("kill_drained_empty", empty, 1);

        // Wrap-around with continuous drain; older store lands in slot 7, younger in slot 1.
        do_reset();
        for (int i = 0; i < 23; i++) begin
            s_ev = 1; s_addr = 30'h100 + 30'(i); s_data = $urandom; s_mask = 4'hF;
            s_commit = (mcmt < mq.size());
            s_dr = 1;
            tick();
        end
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            s_commit = (mcmt < mq.size());
            s_dr = 1;
            tick();
        end
        chk("wrap_flushed", mq.size(), 0);
        enq(30'hA0, 32'hAAAA_AAAA, 4'hF);
        enq(30'hB0, 32'h0BB0_0BB0, 4'hF);
        enq(30'hA0, 32'h5555_5555, 4'hF);
        lookup(30'hA0, 4'hF);
        #1;
        chk("wrap_young_data", fwd_data, 32'h5555_5555);
        tick();

        // Asynchronous reset with a lookup result in flight.
        do_reset();
        for (int i = 0; i < 4; i++) enq(30'h70 + 30'(i), 32'h7000_0000 + 32'(i), 4'hF);
        s_commit = 1; tick();
        lookup(30'h71, 4'hF);
        #1;
        chk("pre_rst_fwd_valid", fwd_valid, 1);
        rst = 0;
        drive_idle();
        #1;
        check_reset_outputs("async");
        mq.delete();
        mcmt = 0;
        exp_fwd.delete();
        fwd_pend = 0;
        @(negedge clk);
        rst = 1;
        tick();

        // Mixed random traffic over a small address set.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            s_ev     = $urandom_range(0, 1);
            s_addr   = 30'h20 + 30'($urandom_range(0, 3));
            s_data   = $urandom;
            s_mask   = 4'($urandom_range(0, 15));
            s_commit = (mcmt < mq.size()) && ($urandom_range(0, 1) == 1);
            s_kill   = ($urandom_range(0, 15) == 0);
            s_dr     = $urandom_range(0, 1);
            s_ldv    = $urandom_range(0, 1);
            s_lda    = 30'h20 + 30'($urandom_range(0, 3));
            s_ldm    = 4'($urandom_range(0, 15));
            tick();
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
